// File: rtl/temporizador_regressivo_pkg.sv
// Shared types and constants for the MM:SS BCD countdown timer.
// Preset word layout is {min_d, min_u, sec_d, sec_u}, one BCD nibble each.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} timer_state_t;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam int         DIGIT_W   = 4;
  localparam int         NUM_DIG   = 4;
  localparam int         SEC_U_LSB = 0;
  localparam int         SEC_D_LSB = 4;
  localparam int         MIN_U_LSB = 8;
  localparam int         MIN_D_LSB = 12;

  typedef struct packed {
    logic [3:0] min_d;
    logic [3:0] min_u;
    logic [3:0] sec_d;
    logic [3:0] sec_u;
  } preset_t;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] mx);
    return (d > mx) ? mx : d;
  endfunction

  // Out-of-range nibbles saturate to the digit maximum rather than wrapping.
  function automatic preset_t clamp_preset(input logic [15:0] raw, input logic [3:0] sec_tens_max);
    preset_t p;
    p.min_d = clamp_digit(raw[MIN_D_LSB +: DIGIT_W], BCD_MAX);
    p.min_u = clamp_digit(raw[MIN_U_LSB +: DIGIT_W], BCD_MAX);
    p.sec_d = clamp_digit(raw[SEC_D_LSB +: DIGIT_W], sec_tens_max);
    p.sec_u = clamp_digit(raw[SEC_U_LSB +: DIGIT_W], BCD_MAX);
    return p;
  endfunction

endpackage

// File: rtl/contador_mod10_down.sv
// One BCD down-counter digit with synchronous load and borrow chaining.
// Wraps from 0 to MAX when borrowed from.
module contador_mod10_down #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       borrow_in,
  output logic [3:0] valor,
  output logic       borrow_out
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          valor <= 4'd0;
    else if (load)      valor <= load_val;
    else if (borrow_in) valor <= (valor == 4'd0) ? MAX : valor - 4'd1;
  end

  assign borrow_out = borrow_in & (valor == 4'd0);

endmodule

// File: rtl/temporizador_regressivo.sv
// MM:SS BCD countdown timer: preset load with clamping, run/pause FSM,
// borrow-chained digit counters and a one-cycle completion pulse.
module temporizador_regressivo
  import timer_pkg::*;
#(
  parameter bit AUTO_RELOAD  = 1'b0,
  parameter int SEC_TENS_MAX = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        start,
  input  logic        pause,
  output logic [3:0]  min_d,
  output logic [3:0]  min_u,
  output logic [3:0]  sec_d,
  output logic [3:0]  sec_u,
  output logic        running,
  output logic        zero,
  output logic        done
);

  timer_state_t                           state_q, state_d;
  preset_t                                load_clamped;
  logic [15:0]                            preset_q;
  logic [15:0]                            cnt_load_val;
  logic                                   cnt_load;
  logic                                   dec;
  logic                                   done_d;
  logic [NUM_DIG-1:0][DIGIT_W-1:0]        digit;
  logic [NUM_DIG:0]                       borrow;
  logic                                   borrow_unused;

  assign load_clamped  = clamp_preset(load_value, 4'(SEC_TENS_MAX));
  assign zero          = (digit == '0);
  assign running       = (state_q == RUN);
  assign borrow_unused = borrow[NUM_DIG];

  // Command priority load > pause > start > tick; a tick sharing an edge with
  // any command is dropped.
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = load_clamped;
    dec          = 1'b0;
    done_d       = 1'b0;
    if (load) begin
      cnt_load = 1'b1;
      state_d  = IDLE;
    end else if (pause) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (start) begin
      if ((state_q == IDLE || state_q == PAUSE) && !zero) state_d = RUN;
    end else if (tick && state_q == RUN) begin
      if (digit == 16'h0001) begin
        done_d = 1'b1;
        if (AUTO_RELOAD) begin
          // Skip 00:00 and land directly on the preset.
          cnt_load     = 1'b1;
          cnt_load_val = preset_q;
          if (preset_q == 16'h0000) state_d = DONE;
        end else begin
          dec     = 1'b1;
          state_d = DONE;
        end
      end else begin
        dec = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      preset_q <= 16'h0000;
      done     <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      if (load) preset_q <= load_clamped;
    end
  end

  assign borrow[0] = dec;

  genvar i;
  generate
    for (i = 0; i < NUM_DIG; i++) begin : g_dig
      contador_mod10_down #(
        .MAX((i == 1) ? 4'(SEC_TENS_MAX) : BCD_MAX)
      ) u_dig (
        .clk       (clk),
        .reset     (reset),
        .load      (cnt_load),
        .load_val  (cnt_load_val[i*DIGIT_W +: DIGIT_W]),
        .borrow_in (borrow[i]),
        .valor     (digit[i]),
        .borrow_out(borrow[i+1])
      );
    end
  endgenerate

  assign sec_u = digit[0];
  assign sec_d = digit[1];
  assign min_u = digit[2];
  assign min_d = digit[3];

endmodule

// File: tb/tb_temporizador_regressivo.sv
// Directed bench: vector table on a non-reloading timer, plus hand sequences
// for async reset mid-count and auto-reload on a second instance.
module tb_temporizador_regressivo;

  logic        clk = 1'b0;
  logic        reset, tick, load, start, pause;
  logic [15:0] load_value;

  logic [3:0] a_min_d, a_min_u, a_sec_d, a_sec_u;
  logic       a_running, a_zero, a_done;
  logic [3:0] b_min_d, b_min_u, b_sec_d, b_sec_u;
  logic       b_running, b_zero, b_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  temporizador_regressivo #(.AUTO_RELOAD(1'b0), .SEC_TENS_MAX(5)) dut_a (
    .clk(clk), .reset(reset), .tick(tick), .load(load), .load_value(load_value),
    .start(start), .pause(pause),
    .min_d(a_min_d), .min_u(a_min_u), .sec_d(a_sec_d), .sec_u(a_sec_u),
    .running(a_running), .zero(a_zero), .done(a_done));

  temporizador_regressivo #(.AUTO_RELOAD(1'b1), .SEC_TENS_MAX(5)) dut_b (
    .clk(clk), .reset(reset), .tick(tick), .load(load), .load_value(load_value),
    .start(start), .pause(pause),
    .min_d(b_min_d), .min_u(b_min_u), .sec_d(b_sec_d), .sec_u(b_sec_u),
    .running(b_running), .zero(b_zero), .done(b_done));

  wire [15:0] a_dig = {a_min_d, a_min_u, a_sec_d, a_sec_u};
  wire [15:0] b_dig = {b_min_d, b_min_u, b_sec_d, b_sec_u};

  typedef struct {
    logic        ld;
    logic [15:0] lv;
    logic [2:0]  cmd;   // {start, pause, tick}
    logic [15:0] ed;
    logic [2:0]  flg;   // {running, done, zero}
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic ld, input logic [15:0] lv, input logic [2:0] cmd,
                     input logic [15:0] ed, input logic [2:0] flg);
    vec_t v;
    v.ld = ld; v.lv = lv; v.cmd = cmd; v.ed = ed; v.flg = flg;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ld, input logic [15:0] lv, input logic [2:0] cmd);
    load = ld; load_value = lv; {start, pause, tick} = cmd;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    load_value = 16'h0000;

    // Table: {load, value, {start,pause,tick}, expected digits, {running,done,zero}}
    add(1'b1, 16'h0003, 3'b000, 16'h0003, 3'b000);
    add(1'b0, 16'h0000, 3'b100, 16'h0003, 3'b100);
    add(1'b0, 16'h0000, 3'b001, 16'h0002, 3'b100);
    add(1'b0, 16'h0000, 3'b001, 16'h0001, 3'b100);
    add(1'b0, 16'h0000, 3'b001, 16'h0000, 3'b011);
    add(1'b0, 16'h0000, 3'b000, 16'h0000, 3'b001);
    add(1'b0, 16'h0000, 3'b100, 16'h0000, 3'b001);
    add(1'b0, 16'h0000, 3'b001, 16'h0000, 3'b001);
    add(1'b1, 16'h1000, 3'b000, 16'h1000, 3'b000);
    add(1'b0, 16'h0000, 3'b100, 16'h1000, 3'b100);
    add(1'b0, 16'h0000, 3'b001, 16'h0959, 3'b100);
    add(1'b1, 16'h0100, 3'b000, 16'h0100, 3'b000);
    add(1'b0, 16'h0000, 3'b100, 16'h0100, 3'b100);
    add(1'b0, 16'h0000, 3'b001, 16'h0059, 3'b100);
    add(1'b1, 16'hFAFF, 3'b000, 16'h9959, 3'b000);
    add(1'b1, 16'h0000, 3'b000, 16'h0000, 3'b001);
    add(1'b0, 16'h0000, 3'b100, 16'h0000, 3'b001);
    add(1'b1, 16'h0005, 3'b000, 16'h0005, 3'b000);
    add(1'b0, 16'h0000, 3'b100, 16'h0005, 3'b100);
    add(1'b0, 16'h0000, 3'b011, 16'h0005, 3'b000);
    for (int k = 0; k < 4; k++) add(1'b0, 16'h0000, 3'b001, 16'h0005, 3'b000);
    add(1'b0, 16'h0000, 3'b100, 16'h0005, 3'b100);
    add(1'b0, 16'h0000, 3'b001, 16'h0004, 3'b100);
    add(1'b0, 16'h0000, 3'b001, 16'h0003, 3'b100);
    add(1'b0, 16'h0000, 3'b101, 16'h0003, 3'b100);
    add(1'b1, 16'h0002, 3'b001, 16'h0002, 3'b000);

    #12;
    chk("rst_digits", a_dig, 16'h0000);
    chk("rst_running", {15'd0, a_running}, 16'd0);
    chk("rst_done", {15'd0, a_done}, 16'd0);
    chk("rst_zero", {15'd0, a_zero}, 16'd1);

    @(negedge clk); reset = 1'b0;
    foreach (vecs[n]) begin
      @(negedge clk);
      drive(vecs[n].ld, vecs[n].lv, vecs[n].cmd);
      @(posedge clk); #1;
      chk($sformatf("v%0d_digits", n), a_dig, vecs[n].ed);
      chk($sformatf("v%0d_flags", n), {13'd0, a_running, a_done, a_zero}, {13'd0, vecs[n].flg});
    end

    // Async reset while running at 00:30.
    @(negedge clk); drive(1'b1, 16'h0030, 3'b000);
    @(negedge clk); drive(1'b0, 16'h0000, 3'b100);
    @(posedge clk); #1;
    chk("mid_pre_digits", a_dig, 16'h0030);
    chk("mid_pre_running", {15'd0, a_running}, 16'd1);
    #2 reset = 1'b1; tick = 1'b1; start = 1'b0;
    #1;
    chk("mid_rst_digits", a_dig, 16'h0000);
    chk("mid_rst_running", {15'd0, a_running}, 16'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("mid_rst_done", {15'd0, a_done}, 16'd0);
    end
    @(negedge clk); reset = 1'b0; tick = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_digits", a_dig, 16'h0000);
    chk("post_rst_running", {15'd0, a_running}, 16'd0);
    @(negedge clk); drive(1'b0, 16'h0000, 3'b100);
    @(posedge clk); #1;
    chk("post_rst_start_zero", {15'd0, a_running}, 16'd0);
    @(negedge clk); drive(1'b1, 16'h0030, 3'b000);
    @(negedge clk); drive(1'b0, 16'h0000, 3'b100);
    @(negedge clk); drive(1'b0, 16'h0000, 3'b001);
    @(posedge clk); #1;
    chk("post_rst_resume", a_dig, 16'h0029);

    // Auto-reload on dut_b, tick held high across the reload.
    @(negedge clk); drive(1'b1, 16'h0002, 3'b000);
    @(posedge clk); #1;
    chk("ar_load", b_dig, 16'h0002);
    @(negedge clk); drive(1'b0, 16'h0000, 3'b100);
    @(negedge clk); drive(1'b0, 16'h0000, 3'b001);
    @(posedge clk); #1;
    chk("ar_t1_digits", b_dig, 16'h0001);
    chk("ar_t1_done", {15'd0, b_done}, 16'd0);
    @(posedge clk); #1;
    chk("ar_t2_digits", b_dig, 16'h0002);
    chk("ar_t2_done", {15'd0, b_done}, 16'd1);
    chk("ar_t2_running", {15'd0, b_running}, 16'd1);
    @(posedge clk); #1;
    chk("ar_t3_digits", b_dig, 16'h0001);
    chk("ar_t3_done", {15'd0, b_done}, 16'd0);
    chk("ar_t3_running", {15'd0, b_running}, 16'd1);
    @(posedge clk); #1;
    chk("ar_t4_done", {15'd0, b_done}, 16'd1);
    @(negedge clk); drive(1'b1, 16'h0007, 3'b000);
    @(posedge clk); #1;
    chk("ar_load_clears_done", {15'd0, b_done}, 16'd0);
    chk("ar_load_idle", {15'd0, b_running}, 16'd0);
    @(negedge clk); drive(1'b0, 16'h0000, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/temporizador_regressivo.md
# temporizador_regressivo

BCD countdown timer (MM:SS, 00:00–99:59). It loads a preset, counts down one second per external `tick` enable pulse, and reports completion with a one-cycle `done` pulse. It is the decrementing counterpart of the lab's mod-10 up-counter chain. It sits beside the display drivers and takes `tick` from the shared prescaler.

## Interface
- `AUTO_RELOAD`, 0: when 1, reaching 00:00 reloads the last loaded preset and keeps running.
- `SEC_TENS_MAX`, 5: maximum value of the seconds-tens digit.
- `clk` input 1: clock.
- `reset` input 1: reset, asynchronous, active-high.
- `tick` input 1: single-cycle count enable, nominally 1 Hz.
- `load` input 1: latch `load_value` as the preset.
- `load_value` input 16: {min_d, min_u, sec_d, sec_u}, 4-bit BCD each.
- `start` input 1: begin or resume counting.
- `pause` input 1: suspend counting.
- `min_d`, `min_u`, `sec_d`, `sec_u` output 4 each: current digits, registered.
- `running` output 1: high in RUN.
- `zero` output 1: all four digits equal 0, decoded from registers.
- `done` output 1: one-cycle completion pulse, registered.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset values: digits 0, preset 0, state IDLE, `running` 0, `done` 0, `zero` 1.
- Priority per edge: `load` > `pause` > `start` > `tick`.
- `load` in any state:
  - Digits and preset take `load_value`.
  - Clamping: a units digit above 9 becomes 9; a `sec_d` above `SEC_TENS_MAX` becomes `SEC_TENS_MAX`.
  - State goes to IDLE; `done` is 0.
- `start`:
  - IDLE or PAUSE with `zero`=0 goes to RUN.
  - With `zero`=1 it is ignored.
  - Ignored in RUN and DONE.
- `pause` in RUN goes to PAUSE; ignored elsewhere.
- `tick`:
  - In RUN only, decrement by one second. Ignored in all other states.
  - A `tick` on the same edge as `start`, `pause` or `load` is dropped.
- Borrow chain: `sec_u` → `sec_d` → `min_u` → `min_d`.
  - A digit decrements when its borrow-in is 1.
  - At 0 it wraps to its maximum: 9, or `SEC_TENS_MAX` for `sec_d`.
  - Borrow-out = borrow-in AND digit==0, combinational.
  - Examples: 10:00 → 09:59; 01:00 → 00:59.
- Reaching 00:00 from 00:01:
  - With `AUTO_RELOAD`=0: state goes to DONE, `done`=1 for exactly one cycle, digits hold 00:00. Only `load` or `reset` leave DONE.
  - With `AUTO_RELOAD`=1: the digits take the preset on that edge instead of 00:00, the state stays RUN and `done` pulses. If the preset is 00:00, the block goes to DONE.
- `running` = (state==RUN).

## Timing
- Digit update latency: the digits change on the same rising edge that samples `tick`=1.
- `done`:
  - Asserts on the edge that performs the final decrement.
  - Deasserts on the next edge unconditionally, even under `load` or back-to-back ticks.
- State changes take effect on the edge that samples the command. The first decrement after `start` needs a later `tick`.
- Asynchronous reset mid-count clears everything immediately, with no `done` pulse. After reset release the block resumes in IDLE on the next edge.
- `tick` held high for several cycles decrements once per cycle. This is legal and is used by the benches.

## Structure
- Package `timer_pkg` holds:
  - `timer_state_t` enum {IDLE, RUN, PAUSE, DONE};
  - constant `BCD_MAX` = 4'd9;
  - the 16-bit preset packing/field offsets.
- Sub-module `contador_mod10_down` (parameter MAX, default 9):
  - ports `clk`, `reset`, `load`, `load_val`[3:0], `borrow_in`, `valor`[3:0], `borrow_out`;
  - instantiated four times, with MAX=`SEC_TENS_MAX` for `sec_d`.
- The top contains the FSM, clamping, preset register and `done` register.

## Test plan
- Preset: reset, load 0x0003, start, three ticks → digits 00:02, 00:01, 00:00. `done` is high for one cycle on the third edge; the state goes to DONE; `running` is 0.
- Borrow/wrap: load 0x1000, start, one tick → 09:59. Load 0x0100, start, tick → 00:59.
- Clamping and zero start: load 0xFAFF → 99:59. Load 0x0000, then start → stays IDLE with `running`=0.
- Pause/priority: run from 00:05, assert `pause` and `tick` together → stays 00:05 in PAUSE. Four ticks are ignored. Start, then two ticks → 00:03.
- Auto-reload (`AUTO_RELOAD`=1): load 0x0002, start, two ticks → 00:02 with a single-cycle `done` and `running` still 1. A third tick → 00:01.
- Reset mid-count: at 00:30 RUN, assert `reset` between edges → digits 00:00 immediately, `done` never pulses, IDLE after release. `start` in DONE is ignored until `load`.
